// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter, MSB first, pattern repeated back-to-back.
// Optional build macro SEQ_TX_LOOP_EN: repeat_n==0 loops the pattern until stop is seen.
module seq_pattern_tx #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(5'b11011),
    parameter int               CNT_W   = 4
) (
    input  logic             clk_pulse,
    input  logic             clear,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
`ifdef SEQ_TX_LOOP_EN
    input  logic             stop,
`endif
    output logic             out_bit,
    output logic             out_valid,
    output logic             busy,
    output logic             frame_done,
    output logic [1:0]       present_state
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] shreg;
    logic [BIT_W-1:0] bitcnt;
    logic [CNT_W-1:0] rep_q;
    logic             start_ok;
    logic             last_bit;
    logic             reload;
`ifdef SEQ_TX_LOOP_EN
    logic             stop_q;
`endif

    // A zero repeat count means "loop forever" only when the loop feature is built in.
`ifdef SEQ_TX_LOOP_EN
    assign start_ok = start;
    assign reload   = (rep_q == '0) ? !(stop_q || stop) : (rep_q > CNT_W'(1));
`else
    assign start_ok = start && (repeat_n != '0);
    assign reload   = rep_q > CNT_W'(1);
`endif

    assign last_bit = (bitcnt == '0);

    always_ff @(posedge clk_pulse or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (last_bit && !reload) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of state and the shift register.
    always_comb begin
        out_bit       = shreg[PAT_W-1];
        out_valid     = (state_q == S_SHIFT);
        busy          = (state_q != S_IDLE);
        frame_done    = (state_q == S_DONE);
        present_state = state_q;
    end

    always_ff @(posedge clk_pulse or posedge clear) begin
        if (clear) begin
            pat_q  <= '0;
            shreg  <= '0;
            bitcnt <= '0;
            rep_q  <= '0;
`ifdef SEQ_TX_LOOP_EN
            stop_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        pat_q  <= use_def ? DEF_PAT : pattern;
                        rep_q  <= repeat_n;
`ifdef SEQ_TX_LOOP_EN
                        stop_q <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    shreg  <= pat_q;
                    bitcnt <= LAST_IDX;
                end
                S_SHIFT: begin
                    // The final shift empties the register, so out_bit idles low afterwards.
                    if (last_bit && reload) begin
                        shreg  <= pat_q;
                        bitcnt <= LAST_IDX;
                        if (rep_q > CNT_W'(1)) rep_q <= rep_q - CNT_W'(1);
                    end else begin
                        shreg <= {shreg[PAT_W-2:0], 1'b0};
                        if (!last_bit) bitcnt <= bitcnt - BIT_W'(1);
                    end
`ifdef SEQ_TX_LOOP_EN
                    if (stop && (rep_q == '0)) stop_q <= 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: queue-based burst model compared every cycle, plus literal checks.
// Build with SEQ_TX_LOOP_EN defined to exercise the continuous mode.
module tb_seq_pattern_tx;

    localparam int PAT_W = 5;
    localparam int CNT_W = 4;
    localparam logic [PAT_W-1:0] DEF_PAT = 5'b11011;
`ifdef SEQ_TX_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic             start = 1'b0;
    logic             use_def = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_n = '0;
`ifdef SEQ_TX_LOOP_EN
    logic             stop = 1'b0;
`endif
    logic             out_bit;
    logic             out_valid;
    logic             busy;
    logic             frame_done;
    logic [1:0]       present_state;

    int checks = 0;
    int failures = 0;
    bit mdl_en = 1'b0;

    seq_pattern_tx #(.PAT_W(PAT_W), .DEF_PAT(DEF_PAT), .CNT_W(CNT_W)) dut (
        .clk_pulse    (clk),
        .clear        (clear),
        .start        (start),
        .use_def      (use_def),
        .pattern      (pattern),
        .repeat_n     (repeat_n),
`ifdef SEQ_TX_LOOP_EN
        .stop         (stop),
`endif
        .out_bit      (out_bit),
        .out_valid    (out_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .present_state(present_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a burst is LOAD, then pattern after pattern of SHIFT bits, then DONE.
    logic [2:0]       mq[$];
    logic [1:0]       m_state;
    logic             m_bit;
    logic [PAT_W-1:0] m_pat;
    int               m_reps;
    bit               m_inf;
    bit               m_stop;

    task automatic push_pattern();
        for (int i = PAT_W - 1; i >= 0; i--) mq.push_back({2'b10, m_pat[i]});
    endtask

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            mq.delete();
            m_state = 2'b00;
            m_bit   = 1'b0;
            m_reps  = 0;
            m_inf   = 1'b0;
            m_stop  = 1'b0;
        end else begin
`ifdef SEQ_TX_LOOP_EN
            if (m_state == 2'b10 && m_inf && stop) m_stop = 1'b1;
`endif
            if (m_state == 2'b00) begin
                if (start && (repeat_n != 0 || LOOP_EN)) begin
                    m_pat  = use_def ? DEF_PAT : pattern;
                    m_reps = int'(repeat_n);
                    m_inf  = (repeat_n == 0);
                    m_stop = 1'b0;
                    mq.push_back(3'b010);
                    push_pattern();
                end
            end else if (mq.size() == 0 && m_state == 2'b10) begin
                if (!m_inf && m_reps > 1) begin
                    m_reps--;
                    push_pattern();
                end else if (m_inf && !m_stop) begin
                    push_pattern();
                end else begin
                    mq.push_back(3'b110);
                end
            end
            if (mq.size() > 0) begin
                {m_state, m_bit} = mq.pop_front();
            end else begin
                m_state = 2'b00;
                m_bit   = 1'b0;
            end
        end
    end

    // Single compare process: {state, valid, busy, frame_done, bit} every cycle.
    always @(negedge clk) begin
        if (mdl_en) begin
            chk("cycle_outputs",
                {58'd0, present_state, out_valid, busy, frame_done, out_bit},
                {58'd0, m_state, (m_state == 2'b10), (m_state != 2'b00), (m_state == 2'b11), m_bit});
        end
    end

    // Observed stream history for the literal burst checks.
    logic [63:0] acc = '0;
    int          vcnt = 0;
    int          fdc = 0;
    always @(negedge clk) begin
        if (out_valid) begin
            acc = {acc[62:0], out_bit};
            vcnt++;
        end
        if (frame_done) fdc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic ud, input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] rn);
        use_def  = ud;
        pattern  = pat;
        repeat_n = rn;
        start    = 1'b1;
        tick(1);
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_burst(input string name, input int bv, input int bfd, input int n,
                             input logic [63:0] bits);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        chk({name, "_len"}, 64'(vcnt - bv), 64'(n));
        chk({name, "_bits"}, acc & mask, bits);
        chk({name, "_done"}, 64'(fdc - bfd), 64'd1);
    endtask

    initial begin
        int bv;
        int bfd;
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int bv;
        int bfd;
        tick(2);
        chk("reset_state", {59'd0, present_state, out_valid, busy, frame_done}, 64'd0);
        chk("reset_bit", {63'd0, out_bit}, 64'd0);
        clear  = 1'b0;
        mdl_en = 1'b1;
        tick(2);

        // Default pattern once, with the start-to-first-bit latency pinned.
        bv = vcnt; bfd = fdc;
        do_start(1'b1, 5'b00000, 4'd1);
        chk("lat_load", {62'd0, present_state}, 64'd1);
        tick(1);
        chk("lat_shift", {62'd0, present_state}, 64'd2);
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
        wait_idle("idle_t2", 20);
        chk_burst("def_x1", bv, bfd, 5, 64'b11011);
        tick(2);

        // User pattern three times; input changes mid-burst must not leak in.
        bv = vcnt; bfd = fdc;
        do_start(1'b0, 5'b10100, 4'd3);
        tick(4);
        pattern  = 5'b01111;
        use_def  = 1'b1;
        repeat_n = 4'd7;
        wait_idle("idle_t3", 40);
        chk_burst("usr_x3", bv, bfd, 15, 64'b101001010010100);
        tick(2);

        // Start held high across a whole burst: restart only from IDLE.
        bv = vcnt; bfd = fdc;
        use_def  = 1'b1;
        repeat_n = 4'd2;
        start    = 1'b1;
        tick(1);
        chk("held_load", {62'd0, present_state}, 64'd1);
        tick(12);
        chk("held_idle", {62'd0, present_state}, 64'd0);
        chk_burst("held_x2", bv, bfd, 10, 64'b1101111011);
        tick(1);
        chk("held_restart", {62'd0, present_state}, 64'd1);
        start = 1'b0;
        wait_idle("idle_t4", 30);
        tick(2);

`ifndef SEQ_TX_LOOP_EN
        do_start(1'b1, 5'b00000, 4'd0);
        for (int i = 0; i < 3; i++) begin
            chk("zero_rep_ignored", {63'd0, busy}, 64'd0);
            tick(1);
        end
`endif

        // Asynchronous clear mid-burst, then a normal burst.
        bfd = fdc;
        do_start(1'b0, 5'b11111, 4'd3);
        tick(6);
        clear = 1'b1;
        #1;
        chk("clear_async", {58'd0, present_state, out_valid, busy, frame_done, out_bit}, 64'd0);
        tick(1);
        clear = 1'b0;
        tick(2);
        chk("clear_no_done", 64'(fdc - bfd), 64'd0);
        bv = vcnt; bfd = fdc;
        do_start(1'b1, 5'b00000, 4'd2);
        wait_idle("idle_t1", 30);
        chk_burst("after_clear", bv, bfd, 10, 64'b1101111011);
        tick(2);

`ifdef SEQ_TX_LOOP_EN
        // Continuous mode: stop during the 7th bit ends after the current pattern.
        bv = vcnt; bfd = fdc;
        do_start(1'b1, 5'b00000, 4'd0);
        tick(7);
        chk("loop_running", {62'd0, present_state}, 64'd2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_idle("idle_t6", 40);
        chk_burst("loop_stop", bv, bfd, 10, 64'b1101111011);
        tick(2);

        // stop is ignored for a counted burst.
        bv = vcnt; bfd = fdc;
        stop = 1'b1;
        do_start(1'b0, 5'b10010, 4'd2);
        wait_idle("idle_t6b", 30);
        stop = 1'b0;
        chk_burst("stop_counted", bv, bfd, 10, 64'b1001010010);
        tick(2);
`endif

        mdl_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
